// File: rtl/uart_mmio_ctrl.sv
// MMIO controller bridging CPU loads/stores to the UART RX/TX handshakes, plus cycle/instruction counters.
// Build option: define UART_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO; otherwise RX is a single-byte holding register.
module uart_mmio_ctrl #(
    parameter int RX_DEPTH = 8,
    parameter int AWIDTH   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    input  logic              inst_retired,
    input  logic [7:0]        uart_rx_data_out,
    input  logic              uart_rx_data_out_valid,
    output logic              uart_rx_data_out_ready,
    output logic [7:0]        uart_tx_data_in,
    output logic              uart_tx_data_in_valid,
    input  logic              uart_tx_data_in_ready
);

    localparam logic [AWIDTH-1:0] OFF_STATUS = AWIDTH'('h00);
    localparam logic [AWIDTH-1:0] OFF_RXDATA = AWIDTH'('h04);
    localparam logic [AWIDTH-1:0] OFF_TXDATA = AWIDTH'('h08);
    localparam logic [AWIDTH-1:0] OFF_CYCLE  = AWIDTH'('h10);
    localparam logic [AWIDTH-1:0] OFF_INSTR  = AWIDTH'('h14);
    localparam logic [AWIDTH-1:0] OFF_CCLEAR = AWIDTH'('h18);

    // The occupancy counter is sized for RX_DEPTH in both builds; only the capacity differs.
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
`ifdef UART_RX_FIFO_EN
    localparam int RX_CAP = RX_DEPTH;
`else
    localparam int RX_CAP = 1;
`endif

    logic load_req;
    logic store_req;
    logic ld_rxdata;
    logic st_status;
    logic st_txdata;
    logic cnt_clear;

    assign load_req  = req_valid & ~req_we;
    assign store_req = req_valid & req_we;
    assign ld_rxdata = load_req  & (req_addr == OFF_RXDATA);
    assign st_status = store_req & (req_addr == OFF_STATUS);
    assign st_txdata = store_req & (req_addr == OFF_TXDATA);
    assign cnt_clear = store_req & (req_addr == OFF_CCLEAR);

    logic unused_wdata_hi;
    assign unused_wdata_hi = ^req_wdata[31:8];

    // Keeps RX ready low until the first clock after reset release.
    logic rst_done_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done_reg <= 1'b0;
        else        rst_done_reg <= 1'b1;
    end

    // ---------------- RX buffer ----------------
    logic [RX_CW-1:0] rx_count_reg;
    logic             rx_full;
    logic             rx_empty;
    logic             rx_push;
    logic             rx_pop;
    logic [7:0]       rx_head;

    assign rx_full  = (rx_count_reg == RX_CW'(RX_CAP));
    assign rx_empty = (rx_count_reg == '0);
    assign uart_rx_data_out_ready = rst_done_reg & ~rx_full;
    assign rx_push  = uart_rx_data_out_valid & uart_rx_data_out_ready;
    assign rx_pop   = ld_rxdata & ~rx_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_count_reg <= '0;
        end else begin
            case ({rx_push, rx_pop})
                2'b10:   rx_count_reg <= rx_count_reg + 1'b1;
                2'b01:   rx_count_reg <= rx_count_reg - 1'b1;
                default: rx_count_reg <= rx_count_reg;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int RX_PW = $clog2(RX_DEPTH);

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_PW-1:0] rx_wr_ptr_reg;
    logic [RX_PW-1:0] rx_rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr_reg] <= uart_rx_data_out;
    end

    // Pointers wrap naturally because RX_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
        end
    end

    assign rx_head = rx_mem[rx_rd_ptr_reg];
`else
    logic [7:0] rx_hold_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rx_hold_reg <= 8'h00;
        else if (rx_push) rx_hold_reg <= uart_rx_data_out;
    end

    assign rx_head = rx_hold_reg;
`endif

    // ---------------- TX holding register ----------------
    logic       tx_valid_reg;
    logic [7:0] tx_data_reg;
    logic       tx_overrun_reg;
    logic       tx_hs;
    logic       tx_accept;
    logic       tx_drop;

    assign tx_hs     = tx_valid_reg & uart_tx_data_in_ready;
    // A store landing on the completing handshake is treated as arriving at an empty register.
    assign tx_accept = st_txdata & (~tx_valid_reg | tx_hs);
    assign tx_drop   = st_txdata & ~tx_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
        end else if (tx_accept) begin
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= req_wdata[7:0];
        end else if (tx_hs) begin
            tx_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        tx_overrun_reg <= 1'b0;
        else if (tx_drop)                  tx_overrun_reg <= 1'b1;
        else if (st_status & req_wdata[2]) tx_overrun_reg <= 1'b0;
    end

    assign uart_tx_data_in       = tx_data_reg;
    assign uart_tx_data_in_valid = tx_valid_reg;

    // ---------------- Counters ----------------
    logic [31:0] cycle_cnt_reg;
    logic [31:0] instr_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
        end else if (cnt_clear) begin
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            if (inst_retired) instr_cnt_reg <= instr_cnt_reg + 32'd1;
        end
    end

    // ---------------- Load path ----------------
    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        case (req_addr)
            OFF_STATUS: rd_val = {29'd0, tx_overrun_reg, ~rx_empty, ~tx_valid_reg};
            OFF_RXDATA: rd_val = rx_empty ? 32'd0 : {24'd0, rx_head};
            OFF_CYCLE:  rd_val = cycle_cnt_reg;
            OFF_INSTR:  rd_val = instr_cnt_reg;
            default:    rd_val = '0;
        endcase
    end

    logic [31:0] rdata_reg;
    logic        rdata_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg       <= '0;
            rdata_valid_reg <= 1'b0;
        end else begin
            rdata_valid_reg <= load_req;
            if (load_req) rdata_reg <= rd_val;
        end
    end

    assign rdata       = rdata_reg;
    assign rdata_valid = rdata_valid_reg;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl: loads and TX bytes queue their expected values, monitors compare on the falling edge.
module tb_uart_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        inst_retired = 1'b0;
    logic [7:0]  uart_rx_data_out = 8'h00;
    logic        uart_rx_data_out_valid = 1'b0;
    logic        uart_rx_data_out_ready;
    logic [7:0]  uart_tx_data_in;
    logic        uart_tx_data_in_valid;
    logic        uart_tx_data_in_ready = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] rd_q [$];
    string       rd_nm [$];
    logic [7:0]  tx_q [$];
    logic [31:0] rd_exp;
    string       rd_name;
    logic [7:0]  tx_exp;

    uart_mmio_ctrl #(.RX_DEPTH(8), .AWIDTH(8)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .req_valid              (req_valid),
        .req_we                 (req_we),
        .req_addr               (req_addr),
        .req_wdata              (req_wdata),
        .rdata                  (rdata),
        .rdata_valid            (rdata_valid),
        .inst_retired           (inst_retired),
        .uart_rx_data_out       (uart_rx_data_out),
        .uart_rx_data_out_valid (uart_rx_data_out_valid),
        .uart_rx_data_out_ready (uart_rx_data_out_ready),
        .uart_tx_data_in        (uart_tx_data_in),
        .uart_tx_data_in_valid  (uart_tx_data_in_valid),
        .uart_tx_data_in_ready  (uart_tx_data_in_ready)
    );

    always #5 clk = ~clk;

    // Monitor: every rdata_valid and every TX handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && rdata_valid) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_miss++;
                $display("FAIL rdata_unexpected: got %h with no load outstanding", rdata);
            end else begin
                rd_exp  = rd_q.pop_front();
                rd_name = rd_nm.pop_front();
                if (rdata !== rd_exp) begin
                    n_miss++;
                    $display("FAIL %s: got %h expected %h", rd_name, rdata, rd_exp);
                end else begin
                    $display("load %s -> %h", rd_name, rdata);
                end
            end
        end
        if (rst_n && uart_tx_data_in_valid && uart_tx_data_in_ready) begin
            n_vec++;
            if (tx_q.size() == 0) begin
                n_miss++;
                $display("FAIL tx_unexpected: got %h with no byte outstanding", uart_tx_data_in);
            end else begin
                tx_exp = tx_q.pop_front();
                if (uart_tx_data_in !== tx_exp) begin
                    n_miss++;
                    $display("FAIL tx_byte: got %h expected %h", uart_tx_data_in, tx_exp);
                end else begin
                    $display("tx byte -> %h", uart_tx_data_in);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("check %s -> %h", name, act);
        end
    endtask

    // Drives one request cycle; called at posedge+1, returns at the next posedge+1.
    task automatic req(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input string name);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        if (!we) begin
            rd_q.push_back(exp);
            rd_nm.push_back(name);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        req_we    = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic rx_push(input logic [7:0] b);
        bit done = 0;
        uart_rx_data_out       = b;
        uart_rx_data_out_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (uart_rx_data_out_ready) done = 1;
            @(posedge clk); #1;
        end
        uart_rx_data_out_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL rx_push_timeout: byte %h never accepted", b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_rdata_valid", {31'd0, rdata_valid}, 32'h0);
        chk("reset_tx_valid", {31'd0, uart_tx_data_in_valid}, 32'h0);
        chk("reset_tx_data", {24'd0, uart_tx_data_in}, 32'h0);
        chk("reset_rx_ready", {31'd0, uart_rx_data_out_ready}, 32'h0);
        rst_n = 1'b1;

        // Back-to-back loads right after release
        req(0, 8'h00, 0, 32'h1, "status_after_reset");
        req(0, 8'h10, 0, 32'h1, "cycle_after_reset");
        idle(1);
        chk("rx_ready_after_reset", {31'd0, uart_rx_data_out_ready}, 32'h1);

        // TX basic, overrun and W1C
        req(1, 8'h08, 32'h141, 0, "");
        tx_q.push_back(8'h41);
        chk("tx_valid_after_store", {31'd0, uart_tx_data_in_valid}, 32'h1);
        chk("tx_data_after_store", {24'd0, uart_tx_data_in}, 32'h41);
        req(1, 8'h08, 32'h42, 0, "");
        req(0, 8'h00, 0, 32'h4, "status_overrun");
        uart_tx_data_in_ready = 1'b1;
        idle(1);
        uart_tx_data_in_ready = 1'b0;
        chk("tx_valid_after_hs", {31'd0, uart_tx_data_in_valid}, 32'h0);
        req(1, 8'h00, 32'h4, 0, "");
        req(0, 8'h00, 0, 32'h1, "status_after_w1c");

        // Store coinciding with handshake completion is accepted
        req(1, 8'h08, 32'h10, 0, "");
        tx_q.push_back(8'h10);
        uart_tx_data_in_ready = 1'b1;
        req(1, 8'h08, 32'h20, 0, "");
        tx_q.push_back(8'h20);
        chk("tx_valid_replaced", {31'd0, uart_tx_data_in_valid}, 32'h1);
        chk("tx_data_replaced", {24'd0, uart_tx_data_in}, 32'h20);
        idle(1);
        uart_tx_data_in_ready = 1'b0;
        req(0, 8'h00, 0, 32'h1, "status_no_overrun");
        idle(1);

        // RX basic
`ifdef UART_RX_FIFO_EN
        rx_push(8'hA5);
        rx_push(8'h5A);
        req(0, 8'h00, 0, 32'h3, "status_rx_valid");
        req(0, 8'h04, 0, 32'hA5, "rx_first");
        req(0, 8'h04, 0, 32'h5A, "rx_second");
`else
        rx_push(8'hA5);
        chk("rx_ready_full_hold", {31'd0, uart_rx_data_out_ready}, 32'h0);
        req(0, 8'h00, 0, 32'h3, "status_rx_valid");
        req(0, 8'h04, 0, 32'hA5, "rx_first");
        idle(1);
        chk("rx_ready_after_pop", {31'd0, uart_rx_data_out_ready}, 32'h1);
        rx_push(8'h5A);
        req(0, 8'h04, 0, 32'h5A, "rx_second");
`endif
        req(0, 8'h04, 0, 32'h0, "rx_empty_read");
        req(0, 8'h00, 0, 32'h1, "status_rx_empty");
        idle(1);

        // Byte pushed in the same cycle as a load is not visible to it
        uart_rx_data_out       = 8'h77;
        uart_rx_data_out_valid = 1'b1;
        req(0, 8'h04, 0, 32'h0, "rx_same_cycle_push");
        uart_rx_data_out_valid = 1'b0;
        req(0, 8'h04, 0, 32'h77, "rx_after_push");
        idle(1);

`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 8; i++) rx_push(8'(i));
        chk("rx_ready_fifo_full", {31'd0, uart_rx_data_out_ready}, 32'h0);
        req(0, 8'h04, 0, 32'h1, "rx_fifo_pop1");
        idle(1);
        chk("rx_ready_after_fifo_pop", {31'd0, uart_rx_data_out_ready}, 32'h1);
        uart_rx_data_out       = 8'h09;
        uart_rx_data_out_valid = 1'b1;
        req(0, 8'h04, 0, 32'h2, "rx_fifo_pushpop");
        uart_rx_data_out_valid = 1'b0;
        idle(1);
        chk("rx_ready_count7", {31'd0, uart_rx_data_out_ready}, 32'h1);
        rx_push(8'h0A);
        chk("rx_ready_refull", {31'd0, uart_rx_data_out_ready}, 32'h0);
        for (int i = 3; i <= 10; i++) req(0, 8'h04, 0, 32'(i), "rx_fifo_drain");
        req(0, 8'h04, 0, 32'h0, "rx_fifo_drained");
        idle(1);
`endif

        // Counters
        inst_retired = 1'b1;
        idle(5);
        inst_retired = 1'b0;
        req(0, 8'h14, 0, 32'h5, "instr_count5");
        inst_retired = 1'b1;
        req(1, 8'h18, 32'h1, 0, "");
        inst_retired = 1'b0;
        req(0, 8'h10, 0, 32'h0, "cycle_after_clear");
        req(0, 8'h14, 0, 32'h0, "instr_after_clear");
        req(0, 8'h2C, 0, 32'h0, "unmapped_2c");
        req(0, 8'h08, 0, 32'h0, "writeonly_08");
        req(0, 8'h18, 0, 32'h0, "writeonly_18");
        idle(1);

        // Async reset mid-run with TX valid high and nonzero rdata
        req(0, 8'h00, 0, 32'h1, "status_pre_reset");
        req(1, 8'h08, 32'h99, 0, "");
        idle(0);
        chk("tx_valid_pre_reset", {31'd0, uart_tx_data_in_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_rdata", rdata, 32'h0);
        chk("midreset_rdata_valid", {31'd0, rdata_valid}, 32'h0);
        chk("midreset_tx_valid", {31'd0, uart_tx_data_in_valid}, 32'h0);
        chk("midreset_tx_data", {24'd0, uart_tx_data_in}, 32'h0);
        chk("midreset_rx_ready", {31'd0, uart_rx_data_out_ready}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req(0, 8'h00, 0, 32'h1, "status_after_rereset");
        req(0, 8'h10, 0, 32'h1, "cycle_after_rereset");
        idle(3);

        chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);
        chk("tx_queue_drained", 32'(tx_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
